// File: rtl/mdr_mem_if.sv
// MAR/MDR memory interface: latches address/data from the datapath bus and runs
// single read/write handshakes with memory. Optional wait timeout: MDR_TIMEOUT_EN.
module mdr_mem_if #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              start_read,
  input  logic              start_write,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [31:0]       MDR_Data_Out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // A zero timeout would make the wait states exit immediately.
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be non-zero");
  end

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   mdr;
  logic                rd_load_c;
  logic                tmo_hit_c;
  logic                tmo_fire_c;
  logic                reg_en_c;

  // Next-state decode; ack wins over a coincident timeout.
  always_comb begin
    state_nxt  = state;
    rd_load_c  = 1'b0;
    tmo_fire_c = 1'b0;
    case (state)
      IDLE: begin
        if (start_read) begin
          state_nxt = RD_WAIT;
        end else if (start_write) begin
          state_nxt = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          state_nxt = DONE;
          rd_load_c = 1'b1;
        end else if (tmo_hit_c) begin
          state_nxt  = DONE;
          tmo_fire_c = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          state_nxt = DONE;
        end else if (tmo_hit_c) begin
          state_nxt  = DONE;
          tmo_fire_c = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      mem_req <= (state_nxt == RD_WAIT) || (state_nxt == WR_WAIT);
      mem_we  <= (state_nxt == WR_WAIT);
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
    end
  end

  assign reg_en_c = (state == IDLE) || (state == DONE);

  // Bus loads are locked out while a transfer is outstanding; read data beats a bus load.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (reg_en_c && MARin) begin
        mar <= BusMuxOut[ADDR_W-1:0];
      end
      if (rd_load_c) begin
        mdr <= mem_rdata;
      end else if (reg_en_c && MDRin) begin
        mdr <= BusMuxOut;
      end
    end
  end

  assign mem_addr     = mar;
  assign mem_wdata    = mdr;
  assign MDR_Data_Out = mdr;

`ifdef MDR_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // Counter is held clear outside the wait states, so every entry starts at zero.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state == RD_WAIT || state == WR_WAIT) && !mem_ack) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (tmo_fire_c) begin
        err_q <= 1'b1;
      end
    end
  end

  assign tmo_hit_c = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign err       = err_q;
`else
  assign tmo_hit_c = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed self-checking bench for mdr_mem_if (timeout case only with MDR_TIMEOUT_EN).
module tb_mdr_mem_if;

  localparam int unsigned ADDR_W = 9;

  logic              clock;
  logic              clear_n;
  logic [31:0]       BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              start_read;
  logic              start_write;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       MDR_Data_Out;
  logic              busy;
  logic              done;
  logic              err;

  int unsigned n_checks;
  int unsigned n_errors;

  mdr_mem_if #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(16)) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .BusMuxOut    (BusMuxOut),
    .MARin        (MARin),
    .MDRin        (MDRin),
    .start_read   (start_read),
    .start_write  (start_write),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .MDR_Data_Out (MDR_Data_Out),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    clear_n     = 1'b0;
    BusMuxOut   = '0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    start_read  = 1'b0;
    start_write = 1'b0;
    mem_rdata   = '0;
    mem_ack     = 1'b0;

    #12;
    check("rst_req",  32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err), 32'd0);
    check("rst_mdr",  MDR_Data_Out, 32'd0);
    check("rst_mar",  32'(mem_addr), 32'd0);
    clear_n = 1'b1;
    tick();

    // bus load into MDR
    BusMuxOut = 32'hDEADBEEF; MDRin = 1'b1;
    tick();
    MDRin = 1'b0;
    check("busload_mdr", MDR_Data_Out, 32'hDEADBEEF);
    check("busload_req", 32'(mem_req), 32'd0);

    // read at MAR=0x05, ack after 3 request cycles
    BusMuxOut = 32'h0000_0005; MARin = 1'b1;
    tick();
    MARin = 1'b0;
    check("rd_addr", 32'(mem_addr), 32'h5);
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rd_req", 32'(mem_req), 32'd1);
      check("rd_we",  32'(mem_we), 32'd0);
      check("rd_done_low", 32'(done), 32'd0);
      if (i == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
      end
      tick();
    end
    mem_ack = 1'b0;
    check("rd_done", 32'(done), 32'd1);
    check("rd_req_drop", 32'(mem_req), 32'd0);
    check("rd_mdr", MDR_Data_Out, 32'h12345678);
    tick();
    check("rd_done_once", 32'(done), 32'd0);
    check("rd_idle", 32'(busy), 32'd0);

    // write MDR=0xA5A5A5A5 to MAR=0x1FF, ack after 1 cycle
    BusMuxOut = 32'h0000_01FF; MARin = 1'b1;
    tick();
    MARin = 1'b0;
    BusMuxOut = 32'hA5A5A5A5; MDRin = 1'b1;
    tick();
    MDRin = 1'b0;
    start_write = 1'b1;
    tick();
    start_write = 1'b0;
    check("wr_req",   32'(mem_req), 32'd1);
    check("wr_we",    32'(mem_we), 32'd1);
    check("wr_addr",  32'(mem_addr), 32'h1FF);
    check("wr_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_ack = 1'b0;
    check("wr_done", 32'(done), 32'd1);
    check("wr_mdr_kept", MDR_Data_Out, 32'hA5A5A5A5);
    tick();
    check("wr_done_once", 32'(done), 32'd0);

    // simultaneous starts: read wins; bus loads and starts ignored while waiting
    start_read = 1'b1; start_write = 1'b1;
    tick();
    start_read = 1'b0; start_write = 1'b0;
    check("cf_req", 32'(mem_req), 32'd1);
    check("cf_we",  32'(mem_we), 32'd0);
    BusMuxOut = 32'h0000_0001; MDRin = 1'b1; MARin = 1'b1; start_write = 1'b1;
    tick();
    MDRin = 1'b0; MARin = 1'b0; start_write = 1'b0;
    check("cf_mdr_locked", MDR_Data_Out, 32'hA5A5A5A5);
    check("cf_mar_locked", 32'(mem_addr), 32'h1FF);
    check("cf_still_rd", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    check("cf_mdr_rd", MDR_Data_Out, 32'hCAFEF00D);
    tick();

    // stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'h0000FFFF;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_mdr", MDR_Data_Out, 32'hCAFEF00D);

    // MDRin with start_read in IDLE: bus loads, then read data overwrites
    BusMuxOut = 32'h11112222; MDRin = 1'b1; start_read = 1'b1;
    tick();
    MDRin = 1'b0; start_read = 1'b0;
    check("co_mdr_bus", MDR_Data_Out, 32'h11112222);
    mem_ack = 1'b1; mem_rdata = 32'h33334444;
    tick();
    mem_ack = 1'b0;
    check("co_mdr_rd", MDR_Data_Out, 32'h33334444);
    tick();

    // reset mid-read
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    check("rr_req", 32'(mem_req), 32'd1);
    #2 clear_n = 1'b0;
    #1;
    check("rr_req_async", 32'(mem_req), 32'd0);
    check("rr_mdr", MDR_Data_Out, 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    tick();
    clear_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h00000077;
    tick();
    mem_ack = 1'b0;
    check("rr_late_ack_mdr", MDR_Data_Out, 32'd0);
    check("rr_late_ack_done", 32'(done), 32'd0);
    check("rr_late_ack_busy", 32'(busy), 32'd0);

`ifdef MDR_TIMEOUT_EN
    BusMuxOut = 32'h5A5A0000; MDRin = 1'b1;
    tick();
    MDRin = 1'b0;
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("to_wait_req", 32'(mem_req), 32'd1);
      check("to_wait_err", 32'(err), 32'd0);
      tick();
    end
    check("to_done", 32'(done), 32'd1);
    check("to_err",  32'(err), 32'd1);
    check("to_mdr",  MDR_Data_Out, 32'h5A5A0000);
    tick();
    check("to_idle", 32'(busy), 32'd0);
    check("to_err_sticky", 32'(err), 32'd1);
`else
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("nt_still_wait", 32'(mem_req), 32'd1);
    check("nt_err", 32'(err), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h00C0FFEE;
    tick();
    mem_ack = 1'b0;
    check("nt_done", 32'(done), 32'd1);
    check("nt_mdr", MDR_Data_Out, 32'h00C0FFEE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
